uart_receiver: RTL

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver_pkg.sv | 35 +++
 rtl/uart_receiver_baud_gen.sv | 30 +++
 rtl/uart_receiver.sv | 119 +++++++++++
 3 files changed

// File: rtl/uart_receiver_pkg.sv
// Shared constants and types for the UART receiver: FSM states, oversampling
// constants and the per-rate sample-enable divisor table.
package uart_receiver_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DIV_WIDTH  = 14;

    localparam logic [3:0] START_MID = 4'd7;
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Index with baud_select; element 0 (300 baud) is the rightmost entry.
    localparam logic [7:0][DIV_WIDTH-1:0] BAUD_DIV = {
        14'd27,     // 111: 115200
        14'd54,     // 110: 57600
        14'd81,     // 101: 38400
        14'd163,    // 100: 19200
        14'd326,    // 011: 9600
        14'd651,    // 010: 4800
        14'd2604,   // 001: 1200
        14'd10417   // 000: 300
    };

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_receiver_baud_gen.sv
// 16x oversampling sample-enable generator; a rate change is picked up only
// when the counter wraps so the current sample period always completes.
module rx_baud_rate_generator (
    input  logic       Clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    output logic       Rx_Sample_ENABLE
);
    import uart_receiver_pkg::*;

    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] div;
    logic                 wrap;

    assign wrap             = (cnt == div - DIV_WIDTH'(1));
    assign Rx_Sample_ENABLE = wrap;

    always_ff @(posedge Clk) begin
        if (!reset) begin
            cnt <= '0;
            div <= BAUD_DIV[baud_select];
        end else if (wrap) begin
            cnt <= '0;
            div <= BAUD_DIV[baud_select];
        end else begin
            cnt <= cnt + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 8 data bits, even parity, 1 stop bit, 16x oversampled.
// Holds the line synchronizer, the frame FSM and the output registers.
module uart_receiver (
    input  logic       Clk,
    input  logic       reset,
    input  logic       RxD,
    input  logic       Rx_EN,
    input  logic [2:0] baud_select,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR
);
    import uart_receiver_pkg::*;

    logic      tick;
    logic      sync_q1;
    logic      sync_q2;
    rx_state_t state;
    logic [3:0] s;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic       parity_bit;
    // Cleared by a framing error; a high sample must be seen before re-arming.
    logic       armed;

    rx_baud_rate_generator u_baud (
        .Clk              (Clk),
        .reset            (reset),
        .baud_select      (baud_select),
        .Rx_Sample_ENABLE (tick)
    );

    always_ff @(posedge Clk) begin
        if (!reset) begin
            sync_q1    <= 1'b1;
            sync_q2    <= 1'b1;
            state      <= IDLE;
            s          <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            armed      <= 1'b1;
            Rx_DATA    <= '0;
            Rx_VALID   <= 1'b0;
            Rx_PERROR  <= 1'b0;
            Rx_FERROR  <= 1'b0;
        end else begin
            sync_q1  <= RxD;
            sync_q2  <= sync_q1;
            Rx_VALID <= 1'b0;

            if (!Rx_EN) begin
                state   <= IDLE;
                s       <= '0;
                bit_idx <= '0;
            end else if (tick) begin
                case (state)
                    IDLE: begin
                        if (sync_q2) begin
                            armed <= 1'b1;
                        end else if (armed) begin
                            state <= START;
                            s     <= '0;
                        end
                    end
                    START: begin
                        if (s == START_MID) begin
                            state   <= sync_q2 ? IDLE : DATA;
                            s       <= '0;
                            bit_idx <= '0;
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                    DATA: begin
                        // s wraps 15 -> 0 between data bits without leaving DATA
                        s <= s + 4'd1;
                        if (s == LAST_TICK) begin
                            shreg   <= {sync_q2, shreg[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                state <= PARITY;
                                s     <= '0;
                            end
                        end
                    end
                    PARITY: begin
                        if (s == LAST_TICK) begin
                            parity_bit <= sync_q2;
                            state      <= STOP;
                            s          <= '0;
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                    STOP: begin
                        if (s == LAST_TICK) begin
                            Rx_DATA   <= shreg;
                            Rx_PERROR <= (parity_bit != even_parity(shreg));
                            Rx_FERROR <= ~sync_q2;
                            Rx_VALID  <= 1'b1;
                            armed     <= sync_q2;
                            state     <= IDLE;
                            s         <= '0;
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        s     <= '0;
                    end
                endcase
            end
        end
    end

endmodule
